// File: rtl/data_mem_pkg.sv
// data_mem_pkg
// Shared definitions for the MEM-stage data memory unit: access-size codes,
// FSM state encoding, and the lane helpers used to build byte enables,
// place store data and extend load data.
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Reserved size, odd halfword, or unaligned word.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
        access_err = (size == 2'b11)
                  || (size == SZ_HALF && addr_lo[0])
                  || (size == SZ_WORD && addr_lo != 2'b00);
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
        byte_en = '0;
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << addr_lo;
            SZ_HALF: byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: byte_en = 4'b1111;
            default: byte_en = '0;
        endcase
    endfunction

    // Replicate right-aligned store data into every lane; byte enables pick the live one.
    function automatic logic [31:0] store_lanes(input logic [31:0] wdata, input logic [1:0] size);
        store_lanes = wdata;
        case (size)
            SZ_BYTE: store_lanes = {4{wdata[7:0]}};
            SZ_HALF: store_lanes = {2{wdata[15:0]}};
            default: store_lanes = wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] addr_lo, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = '0;
        h = '0;
        load_extend = '0;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0:    b = word[7:0];
                    2'd1:    b = word[15:8];
                    2'd2:    b = word[23:16];
                    default: b = word[31:24];
                endcase
                load_extend = {{24{sgn & b[7]}}, b};
            end
            SZ_HALF: begin
                h = addr_lo[1] ? word[31:16] : word[15:0];
                load_extend = {{16{sgn & h[15]}}, h};
            end
            SZ_WORD: load_extend = word;
            default: load_extend = '0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank
// Byte-enabled synchronous single-port RAM, DEPTH_WORDS x 32, registered read.
// Ports:
//   clk      in   clock, rising edge
//   en_i     in   access strobe (read always, write per we_i)
//   we_i     in   per-byte write enables, lane k = bits [8k+7:8k]
//   addr_i   in   word index
//   wdata_i  in   write data, already lane-placed
//   rdata_o  out  word read on the last enabled edge (old contents)
module dmem_bank
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
)
(
    input  logic              clk,
    input  logic              en_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (we_i[k]) mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_unit.sv
// data_mem_unit
// MEM-stage data memory: byte/half/word loads and stores with sign or zero
// extension, alignment and reserved-size error detection, valid/ready
// request with a one-cycle response pulse after WAIT_CYCLES wait states.
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   req_valid / req_ready  request handshake, accepted when both high
//   req_write              1 = store, 0 = load
//   req_size               00 byte, 01 half, 10 word, 11 reserved
//   req_signed             loads: sign-extend when 1
//   req_addr               byte address (wraps modulo DEPTH_WORDS*4)
//   req_wdata              right-aligned store data
//   resp_valid             one-cycle response pulse
//   resp_rdata             extended load data, 0 for stores and errors
//   resp_error             misaligned / reserved-size access
//   busy                   accepted request not yet answered
module data_mem_unit
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        busy
);

    localparam int unsigned CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    // With no wait states the RAM must be driven straight from the request inputs.
    localparam bit DIRECT = (WAIT_CYCLES == 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, signed_q;
    logic [1:0]        size_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              accept;

    logic              op_write;
    logic [1:0]        op_size;
    logic [ADDR_W+1:0] op_addr;
    logic [31:0]       op_wdata;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [31:0]       ram_rdata;
    logic              resp_err_w;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    // Gated by reset so every output reads 0 while reset is held.
    assign req_ready = !reset && (state_q == IDLE || state_q == RESP);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    state_d = DIRECT ? RESP : WAIT;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            write_q  <= req_write;
            signed_q <= req_signed;
            size_q   <= req_size;
            addr_q   <= req_addr[ADDR_W+1:0];
            wdata_q  <= req_wdata;
        end
    end

    // The RAM access happens on the edge that enters RESP.
    assign op_write = DIRECT ? req_write             : write_q;
    assign op_size  = DIRECT ? req_size              : size_q;
    assign op_addr  = DIRECT ? req_addr[ADDR_W+1:0]  : addr_q;
    assign op_wdata = DIRECT ? req_wdata             : wdata_q;
    assign ram_en   = DIRECT ? accept : (state_q == WAIT && cnt_q == '0);
    assign ram_we   = (op_write && !access_err(op_size, op_addr[1:0]))
                    ? byte_en(op_size, op_addr[1:0]) : '0;

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (op_addr[ADDR_W+1:2]),
        .wdata_i (store_lanes(op_wdata, op_size)),
        .rdata_o (ram_rdata)
    );

    assign resp_err_w = access_err(size_q, addr_q[1:0]);
    assign resp_valid = (state_q == RESP);
    assign resp_error = resp_valid && resp_err_w;
    assign resp_rdata = (resp_valid && !write_q && !resp_err_w)
                      ? load_extend(ram_rdata, size_q, addr_q[1:0], signed_q) : '0;
    assign busy       = (state_q == WAIT) || (state_q == RESP && !accept);

endmodule
